des_result_unpacker: RTL and testbench

Downstream consumer of the DES core's result port. It captures each 64-bit `out_data` block qualified by `data_valid` into a small synchronous FIFO, then serialises each block as two 32-bit words, high half first, on a valid/ready stream. The stream feeds the system-side result path. It absorbs back-pressure the DES core cannot take, since the core has no stall input, and flags any block dropped for lack of space.

---
 rtl/des_stream_pkg.sv | 9 +
 rtl/des_result_unpacker_if.sv | 29 ++
 rtl/des_block_fifo.sv | 75 +++++++
 rtl/des_result_unpacker.sv | 89 ++++++++
 tb/tb_des_result_unpacker.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/des_stream_pkg.sv
// Shared widths and types for the DES result stream.
// Types only: no logic, no latency, no flow control.
package des_stream_pkg;
  localparam int DES_BLOCK_W = 64;
  localparam int DES_WORD_W  = 32;

  typedef logic [DES_BLOCK_W-1:0] des_block_t;
  typedef logic [DES_WORD_W-1:0]  des_word_t;
endpackage

// File: rtl/des_result_unpacker_if.sv
// Block capture input plus word stream output of the DES result unpacker.
// The master side feeds blocks and consumes words; the slave side is the unpacker.
interface des_result_unpacker_if
  import des_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DES_BLOCK_W,
  parameter int WORD_WIDTH = DES_WORD_W,
  parameter int DEPTH      = 4
);
  logic                     data_valid;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     clear;
  logic                     word_valid;
  logic [WORD_WIDTH-1:0]    word_data;
  logic                     word_last;
  logic                     word_ready;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;

  modport master (
    output data_valid, out_data, clear, word_ready,
    input  word_valid, word_data, word_last, fifo_level, overflow
  );

  modport slave (
    input  data_valid, out_data, clear, word_ready,
    output word_valid, word_data, word_last, fifo_level, overflow
  );
endinterface

// File: rtl/des_block_fifo.sv
// Generic synchronous FIFO; head visible combinationally, push lands 1 cycle later.
// Push while full is ignored unless a pop happens in the same cycle; clear flushes.
module des_block_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Full is judged after the same-cycle pop, so a pop frees the slot being written.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/des_result_unpacker.sv
// Buffers DES result blocks and streams each as two words, high half first; 1-cycle push latency.
// Absorbs word_ready stalls in the FIFO; blocks arriving while full are dropped and flagged sticky.
module des_result_unpacker
  import des_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DES_BLOCK_W,
  parameter int WORD_WIDTH = DES_WORD_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  des_result_unpacker_if.slave  bus
);
  logic [DATA_WIDTH-1:0]    head_dat;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_level;

  logic                     half_q, half_d;
  logic                     overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0]    last_word_q, last_word_d;

  logic                     word_valid;
  logic [WORD_WIDTH-1:0]    word_mux;
  logic                     xfer;
  logic                     pop_done;
  logic                     push_ok;
  logic                     drop;

  assign word_valid = ~fifo_empty;
  assign word_mux   = half_q ? head_dat[WORD_WIDTH-1:0] : head_dat[DATA_WIDTH-1:WORD_WIDTH];

  assign xfer     = word_valid & bus.word_ready & ~bus.clear;
  assign pop_done = xfer & half_q;
  assign push_ok  = bus.data_valid & (~fifo_full | pop_done) & ~bus.clear;
  assign drop     = bus.data_valid & fifo_full & ~pop_done & ~bus.clear;

  des_block_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.clear),
    .push     (push_ok),
    .push_dat (bus.out_data),
    .pop      (pop_done),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_comb begin
    half_d      = half_q;
    overflow_d  = overflow_q;
    last_word_d = word_valid ? word_mux : last_word_q;
    if (bus.clear) begin
      half_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (xfer) begin
        half_d = ~half_q;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_q      <= 1'b0;
      overflow_q  <= 1'b0;
      last_word_q <= '0;
    end else begin
      half_q      <= half_d;
      overflow_q  <= overflow_d;
      last_word_q <= last_word_d;
    end
  end

  // An empty FIFO keeps showing the last presented word.
  assign bus.word_valid = word_valid;
  assign bus.word_data  = word_valid ? word_mux : last_word_q;
  assign bus.word_last  = word_valid & half_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_des_result_unpacker.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every word transfer.
module tb_des_result_unpacker;
  import des_stream_pkg::*;

  typedef struct packed {
    des_word_t d;
    logic      l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  des_result_unpacker_if #(.DATA_WIDTH(64), .WORD_WIDTH(32), .DEPTH(4)) bus ();

  des_result_unpacker #(.DATA_WIDTH(64), .WORD_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input des_block_t b, input bit hi_only);
    des_word_t hi;
    des_word_t lo;
    hi = b[63:32];
    lo = b[31:0];
    exp_q.push_back('{d: hi, l: 1'b0});
    if (!hi_only) exp_q.push_back('{d: lo, l: 1'b1});
  endtask

  task automatic push_blk(input des_block_t b, input bit expect_out);
    bus.data_valid = 1'b1;
    bus.out_data   = b;
    if (expect_out) enq(b, 1'b0);
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.word_valid), 64'd0);
    check({tag, "_data"},  64'(bus.word_data),  64'd0);
    check({tag, "_last"},  64'(bus.word_last),  64'd0);
    check({tag, "_level"}, 64'(bus.fifo_level), 64'd0);
    check({tag, "_ovf"},   64'(bus.overflow),   64'd0);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst && !bus.clear && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_word: got %h last=%b, expected no word", bus.word_data, bus.word_last);
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {31'd0, bus.word_data, bus.word_last}, {31'd0, mon_e.d, mon_e.l});
      end
    end
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.out_data   = '0;
    bus.clear      = 1'b0;
    bus.word_ready = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single block, consumer always ready.
    bus.word_ready = 1'b1;
    push_blk(64'h0123456789ABCDEF, 1'b1);
    check("t1_valid_lat", 64'(bus.word_valid), 64'd1);
    check("t1_level_a", 64'(bus.fifo_level), 64'd1);
    tick();
    check("t1_level_b", 64'(bus.fifo_level), 64'd1);
    check("t1_last_b", 64'(bus.word_last), 64'd1);
    tick();
    check("t1_level_c", 64'(bus.fifo_level), 64'd0);
    check("t1_valid_c", 64'(bus.word_valid), 64'd0);
    check("t1_hold_data", 64'(bus.word_data), 64'h89ABCDEF);
    check("t1_hold_last", 64'(bus.word_last), 64'd0);

    // Back-pressure: head word must stay stable.
    bus.word_ready = 1'b0;
    push_blk(64'h0123456789ABCDEF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", 64'(bus.word_valid), 64'd1);
      check("t2_data", 64'(bus.word_data), 64'h01234567);
      check("t2_level", 64'(bus.fifo_level), 64'd1);
      tick();
    end
    bus.word_ready = 1'b1;
    tick();
    tick();
    check("t2_level_end", 64'(bus.fifo_level), 64'd0);

    // Fill and overflow: block 5 is dropped.
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_blk(64'(i), i <= 4);
    check("t3_level", 64'(bus.fifo_level), 64'd4);
    check("t3_ovf", 64'(bus.overflow), 64'd1);
    bus.word_ready = 1'b1;
    repeat (10) tick();
    check("t3_level_end", 64'(bus.fifo_level), 64'd0);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);
    check("t3_ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("t3_ovf_clr", 64'(bus.overflow), 64'd0);

    // Full with a completing pop in the same cycle as a push.
    bus.word_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_blk(64'h11 + 64'(i), 1'b1);
    bus.word_ready = 1'b1;
    tick();
    check("t4_half", 64'(bus.word_last), 64'd1);
    push_blk(64'hAA, 1'b1);
    check("t4_level", 64'(bus.fifo_level), 64'd4);
    check("t4_ovf", 64'(bus.overflow), 64'd0);
    repeat (12) tick();
    check("t4_level_end", 64'(bus.fifo_level), 64'd0);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Clear mid-block together with a new block.
    bus.word_ready = 1'b1;
    bus.data_valid = 1'b1;
    bus.out_data   = 64'hA5A5A5A55A5A5A5A;
    enq(64'hA5A5A5A55A5A5A5A, 1'b1);
    tick();
    bus.data_valid = 1'b0;
    tick();
    bus.clear      = 1'b1;
    bus.data_valid = 1'b1;
    bus.out_data   = 64'hDEADBEEFCAFEF00D;
    tick();
    bus.clear      = 1'b0;
    bus.data_valid = 1'b0;
    check("t5_valid", 64'(bus.word_valid), 64'd0);
    check("t5_level", 64'(bus.fifo_level), 64'd0);
    check("t5_ovf", 64'(bus.overflow), 64'd0);
    check("t5_last", 64'(bus.word_last), 64'd0);
    push_blk(64'h1122334455667788, 1'b1);
    check("t5_next_hi", 64'(bus.word_data), 64'h11223344);
    repeat (3) tick();
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with three blocks held.
    bus.word_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_blk(64'hF0F0F0F000000000 + 64'(i), 1'b0);
    check("t6_level_pre", 64'(bus.fifo_level), 64'd3);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.word_ready = 1'b1;
    push_blk(64'h0F1E2D3C4B5A6978, 1'b1);
    check("t6_resume_valid", 64'(bus.word_valid), 64'd1);
    repeat (3) tick();
    check("t6_level_end", 64'(bus.fifo_level), 64'd0);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
